// File: rtl/seq_mul_unit.sv
// Iterative signed shift-add multiplier, one multiplier bit per clock, valid/ready on both sides.
// Optional SEQ_MUL_EARLY_TERM_EN: finish as soon as the remaining multiplier bits are all zero.
module seq_mul_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic               busy
);

  // state | meaning
  // IDLE  | waiting for an operand pair; in_ready high
  // RUN   | one shift-add step per cycle over the multiplier magnitude
  // DONE  | product presented on out_p until out_ready

  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [PW-1:0]     mcand, mcand_n;
  logic [PW-1:0]     acc, acc_n;
  logic [PW-1:0]     out_p_n;
  logic [PW-1:0]     acc_sum;
  logic [WIDTH-1:0]  mplier, mplier_n;
  logic [WIDTH-1:0]  a_mag, b_mag;
  logic [CW-1:0]     cnt, cnt_n;
  logic              neg, neg_n;
  logic              last_step;

  // Magnitude of the most negative value wraps to 2^(WIDTH-1), which is correct as unsigned.
  assign a_mag   = in_a[WIDTH-1] ? -in_a : in_a;
  assign b_mag   = in_b[WIDTH-1] ? -in_b : in_b;
  assign acc_sum = acc + (mplier[0] ? mcand : '0);

`ifdef SEQ_MUL_EARLY_TERM_EN
  assign last_step = (cnt == CW'(WIDTH - 1)) || ((mplier >> 1) == '0);
`else
  assign last_step = (cnt == CW'(WIDTH - 1));
`endif

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_comb begin
    state_n  = state;
    mcand_n  = mcand;
    mplier_n = mplier;
    acc_n    = acc;
    cnt_n    = cnt;
    neg_n    = neg;
    out_p_n  = out_p;
    case (state)
      IDLE: begin
        if (in_valid) begin
          mcand_n  = {{WIDTH{1'b0}}, a_mag};
          mplier_n = b_mag;
          neg_n    = in_a[WIDTH-1] ^ in_b[WIDTH-1];
          acc_n    = '0;
          cnt_n    = '0;
          state_n  = RUN;
        end
      end
      RUN: begin
        acc_n    = acc_sum;
        mcand_n  = mcand << 1;
        mplier_n = mplier >> 1;
        cnt_n    = cnt + 1'b1;
        if (last_step) begin
          out_p_n = neg ? -acc_sum : acc_sum;
          state_n = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      out_p  <= '0;
    end else begin
      state  <= state_n;
      mcand  <= mcand_n;
      mplier <= mplier_n;
      acc    <= acc_n;
      cnt    <= cnt_n;
      neg    <= neg_n;
      out_p  <= out_p_n;
    end
  end

endmodule

// File: tb/tb_seq_mul_unit.sv
// Scoreboard bench for seq_mul_unit: the driver pushes expected products and latencies,
// and an independent monitor pops and compares whenever a product is presented.
module tb_seq_mul_unit;

  localparam int WIDTH = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_a;
  logic [WIDTH-1:0]  in_b;
  logic              out_valid;
  logic              out_ready;
  logic [2*WIDTH-1:0] out_p;
  logic              busy;

  seq_mul_unit #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] p;
    int          lat;
    int          acc_cyc;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  logic        rst_q = 1'b0;
  logic        presented = 1'b0;
  logic [63:0] held = '0;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: plain signed arithmetic; latency from the position of |b|'s top bit.
  function automatic int model_lat(input int b);
    longint mag;
    int     k;
`ifdef SEQ_MUL_EARLY_TERM_EN
    mag = (b < 0) ? -longint'(b) : longint'(b);
    k = 0;
    for (int i = 0; i < 40; i++) if (mag[i]) k = i;
    return k + 1;
`else
    mag = longint'(b);
    k = WIDTH;
    return k;
`endif
  endfunction

  function automatic void push(input int a, input int b, input int acc_cyc);
    exp_t e;
    e.p       = 64'(longint'(a) * longint'(b));
    e.lat     = model_lat(b);
    e.acc_cyc = acc_cyc;
    sb.push_back(e);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_q) begin
      presented = 1'b0;
    end else if (out_valid) begin
      if (!presented) begin
        if (sb.size() == 0) begin
          chk("unexpected_out_valid", 64'(out_valid), 64'd0);
        end else begin
          e = sb.pop_front();
          chk("product", out_p, e.p);
          chk("latency", 64'(cyc - e.acc_cyc), 64'(e.lat));
          held = e.p;
        end
        presented = 1'b1;
      end else begin
        chk("out_p_stable", out_p, held);
      end
      chk("in_ready_low_in_done", 64'(in_ready), 64'd0);
      chk("busy_in_done", 64'(busy), 64'd1);
    end else if (presented) begin
      chk("out_p_kept_after_hs", out_p, held);
      presented = 1'b0;
    end
  end

  task automatic offer(input int a, input int b);
    int n = 0;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (in_ready) push(a, b, cyc + 1);
    else chk("accept_timeout", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) chk("out_valid_timeout", 64'(out_valid), 64'd1);
  endtask

  task automatic do_txn(input int a, input int b, input int hold);
    offer(a, b);
    wait_valid();
    repeat (hold) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    int a, b, got, guard, prev, n;
    bit seen;
    rst = 1'b1;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_p", out_p, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed corners
    do_txn(3, 5, 0);
    do_txn(-7, 6, 1);
    do_txn(int'(32'h8000_0000), int'(32'h8000_0000), 0);
    do_txn(int'(32'h8000_0000), 1, 2);
    do_txn(12345, 0, 0);
    do_txn(0, -9, 0);
    do_txn(3, -8, 0);
    do_txn(-5, 32'h4000_0000, 0);
    do_txn(-1, -1, 0);

    // Backpressure with a competing pair held on the input side
    offer(100, 100);
    wait_valid();
    in_a = 7;
    in_b = 11;
    in_valid = 1'b1;
    repeat (5) @(negedge clk);
    chk("bp_not_accepted", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_idle_after_release", 64'(in_ready), 64'd1);
    push(7, 11, cyc + 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_new_pair_accepted", 64'(in_ready), 64'd0);
    wait_valid();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset in the middle of a run
    offer(9, 9);
`ifdef SEQ_MUL_EARLY_TERM_EN
    repeat (1) @(negedge clk);
`else
    repeat (9) @(negedge clk);
`endif
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_out_p", out_p, 64'd0);
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("abort_never_valid", 64'(seen), 64'd0);
    do_txn(2, 4, 0);

    // Random traffic with random backpressure
    for (int i = 0; i < 20; i++) begin
      a = int'($urandom);
      case ($urandom_range(0, 2))
        0: b = int'($urandom);
        1: b = int'($urandom_range(0, 300)) - 150;
        default: b = int'(32'd1 << $urandom_range(0, 31));
      endcase
      do_txn(a, b, int'($urandom_range(0, 3)));
    end

    // Back-to-back: in_valid and out_ready held high
    got = 0;
    guard = 0;
    prev = 0;
    a = int'($urandom);
    b = int'($urandom);
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    out_ready = 1'b1;
    while (got < 6 && guard < 1000) begin
      if (in_ready) begin
        push(a, b, cyc + 1);
`ifndef SEQ_MUL_EARLY_TERM_EN
        if (got > 0) chk("b2b_interval", 64'(cyc + 1 - prev), 64'(WIDTH + 2));
`endif
        prev = cyc + 1;
        got++;
        @(negedge clk);
        a = int'($urandom);
        b = int'($urandom);
        in_a = a;
        in_b = b;
      end else begin
        @(negedge clk);
      end
      guard++;
    end
    in_valid = 1'b0;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_scoreboard", 64'(sb.size()), 64'd0);
    out_ready = 1'b0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seq_mul_unit.md
# seq_mul_unit

Iterative signed shift-add multiplier with valid/ready handshakes on both sides. It consumes two `int`-width operands from the upstream operand stage and produces the full-width signed product, one multiplier bit per clock. It is the sequential consumer stage behind the combinational statement/loop logic. It is written to exercise `always_ff` state machines, counters and handshake stalls in the simulator flow.

## Interface
Parameters:
- `WIDTH`, default 32: operand width in bits; operands are signed two's complement; product is 2*WIDTH bits.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  reset; synchronous, active-high; has priority over every other input.
- `in_valid`  input  1  operand pair valid.
- `in_ready`  output  1  block can accept an operand pair.
- `in_a`  input  WIDTH  multiplicand, signed.
- `in_b`  input  WIDTH  multiplier, signed.
- `out_valid`  output  1  product valid.
- `out_ready`  input  1  downstream accepts the product.
- `out_p`  output  2*WIDTH  signed product `in_a*in_b`.
- `busy`  output  1  high in RUN or DONE.

## Operation
- FSM states are IDLE, RUN and DONE. Reset state is IDLE.
- Reset values: `in_ready`=1, `out_valid`=0, `out_p`=0, `busy`=0, and all internal registers are 0.
- Output decode: `in_ready` = (state==IDLE); `out_valid` = (state==DONE); `busy` = (state!=IDLE).
- IDLE:
  - On `in_valid && in_ready`, latch `mcand` = |in_a| zero-extended to 2*WIDTH, `mplier` = |in_b| as unsigned WIDTH bits, and `neg` = sign(a) XOR sign(b).
  - Clear `acc`=0 and `cnt`=0, then go to RUN.
- RUN, one step per cycle:
  - If `mplier[0]`, then `acc += mcand`. All arithmetic is mod 2^(2*WIDTH), unsigned.
  - `mcand <<= 1`, `mplier >>= 1`, `cnt++`.
  - When `cnt` reaches WIDTH-1 on this step, this is the last step: register `out_p` = `neg` ? -(acc_next) : acc_next and go to DONE.
- DONE:
  - `out_p` is held stable.
  - On `out_ready`, go to IDLE. `out_p` keeps its value after the handshake, until the next result or reset.
- Magnitude rules:
  - |−2^(WIDTH−1)| = 2^(WIDTH−1) and is representable in WIDTH unsigned bits, so there is no overflow.
  - (−2^31)·(−2^31) = 2^62 fits in 64 bits.
  - A zero operand gives 0 regardless of `neg`.
- `in_valid`, `in_a` and `in_b` are ignored outside IDLE. Operands are sampled only at the accepting edge.
- Reset in RUN or DONE aborts the transaction:
  - State returns to IDLE and `out_valid` falls at that edge.
  - The in-flight result is discarded and never presented.
  - `out_p` returns to 0.

## Timing
- Latency: `out_valid` rises exactly WIDTH cycles after the accepting edge (32 for the default).
- `out_valid` stays high until the edge where `out_ready`=1. `in_ready` rises the cycle after that edge.
- Throughput: one product per WIDTH+2 cycles when `in_valid`=1 and `out_ready`=1 are held constantly. There is no overlap between consecutive operations.
- `out_ready` high while not in DONE has no effect.
- `in_valid` and `out_ready` may change arbitrarily during RUN without effect.

## Configuration
- Macro: `SEQ_MUL_EARLY_TERM_EN`.
- When defined:
  - In RUN, the last step is also taken when `mplier>>1` == 0 after the current step.
  - Latency = max(1, k+1) cycles, where k is the index of the highest set bit of |in_b|.
  - |in_b|=0 gives 1 cycle; |in_b|=1 gives 1 cycle.
  - The result is identical to the non-terminating path.
- When undefined, latency is always WIDTH cycles and the `mplier`-zero check is not compiled.

## Test plan
- Reset, then a=3, b=5: `out_valid` rises 32 cycles after acceptance with `out_p`=15; `in_ready`=0 throughout RUN and DONE.
- a=−7, b=6 gives `out_p`=−42 (0xFFFF_FFFF_FFFF_FFD6). a=−2^31, b=−2^31 gives `out_p`=2^62. a=−2^31, b=1 gives `out_p`=−2^31 sign-extended.
- Backpressure: a=100, b=100 with `out_ready` held 0 for 5 cycles after `out_valid` rises. `out_p`=10000 stays stable and `in_valid`=1 with new operands is ignored. Release `out_ready`: IDLE follows, and the new pair is accepted on the next edge.
- Reset mid-op: accept a=9, b=9 and assert `rst` for one cycle at RUN step 10. `out_valid` never rises and `out_p`=0. A following a=2, b=4 yields 8 after 32 cycles.
- Back-to-back with `in_valid`=`out_ready`=1 continuously: results arrive every 34 cycles, in order and correct.
- With `SEQ_MUL_EARLY_TERM_EN`:
  - b=0 gives latency 1 and `out_p`=0.
  - b=1 gives latency 1.
  - b=−8 gives latency 4 with a=3 and `out_p`=−24.
  - b=0x4000_0000 gives latency 31.
